// File: rtl/gf607_pkg.sv
// Shared constants and state type for the GF(607) inversion datapath.
package gf607_pkg;

    localparam int unsigned GF_P   = 607;
    localparam int unsigned GF_EXP = 605;
    localparam int unsigned ELEM_W = 10;
    localparam int unsigned PROD_W = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/barret_for_607.sv
// Combinational Barrett reduction of a 19-bit product modulo 607.
// mu = floor(2^20 / 607) = 1727; for inputs below 2^19 the quotient estimate
// is short by at most one, so a single conditional subtract finishes it.
module barret_for_607
    import gf607_pkg::*;
(
    input  logic [PROD_W-1:0] din_a,
    output logic [ELEM_W-1:0] dout_r
);

    localparam logic [29:0] MU = 30'd1727;

    logic [9:0]  q;
    logic [10:0] r;

    // True remainder is below 2*607 < 2^11, so 11-bit wraparound arithmetic is exact.
    assign q      = 10'((30'(din_a) * MU) >> 20);
    assign r      = 11'(din_a[10:0] - 11'(20'(q) * 20'(GF_P)));
    assign dout_r = (r >= 11'(GF_P)) ? 10'(r - 11'(GF_P)) : r[9:0];

endmodule

// File: rtl/mod_inverse_607.sv
// Fermat inversion in GF(607): dout_r = din_a^605 mod 607 by left-to-right
// square-and-multiply, one modular product per cycle through a shared reducer.
module mod_inverse_607
    import gf607_pkg::*;
#(
    parameter int unsigned P   = GF_P,
    parameter int unsigned EXP = GF_EXP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ELEM_W-1:0] din_a,
    output logic [ELEM_W-1:0] dout_r,
    output logic              busy,
    output logic              done,
    output logic              no_inv
);

    localparam logic [ELEM_W-1:0] P_E      = ELEM_W'(P);
    localparam logic [9:0]        EXP_BITS = 10'(EXP);

    state_t            state, state_nx;
    logic [ELEM_W-1:0] acc, acc_nx;
    logic [ELEM_W-1:0] base, base_nx;
    logic [3:0]        bit_idx, bit_nx;
    logic [ELEM_W-1:0] dout_nx;
    logic              no_inv_nx;
    logic [ELEM_W-1:0] mul_b;
    logic [PROD_W-1:0] prod;
    logic [ELEM_W-1:0] red_out;

    // Operand mux: squaring reuses acc, multiply step uses the captured base.
    assign mul_b = (state == MUL) ? base : acc;
    assign prod  = PROD_W'(20'(acc) * 20'(mul_b));

    barret_for_607 u_red (
        .din_a  (prod),
        .dout_r (red_out)
    );

    // Status decoded from registered state only.
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= ELEM_W'(1);
            base    <= '0;
            bit_idx <= 4'd9;
            dout_r  <= '0;
            no_inv  <= 1'b0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            base    <= base_nx;
            bit_idx <= bit_nx;
            dout_r  <= dout_nx;
            no_inv  <= no_inv_nx;
        end
    end

    // Next-state and datapath update; results are published only on entry to FIN.
    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        base_nx   = base;
        bit_nx    = bit_idx;
        dout_nx   = dout_r;
        no_inv_nx = no_inv;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SQR;
                    acc_nx   = ELEM_W'(1);
                    base_nx  = (din_a < P_E) ? din_a : din_a - P_E;
                    bit_nx   = 4'd9;
                end
            end
            SQR: begin
                acc_nx = red_out;
                if (EXP_BITS[bit_idx]) begin
                    state_nx = MUL;
                end else if (bit_idx == 4'd0) begin
                    state_nx  = FIN;
                    dout_nx   = red_out;
                    no_inv_nx = (base == '0);
                end else begin
                    bit_nx = bit_idx - 4'd1;
                end
            end
            MUL: begin
                acc_nx = red_out;
                if (bit_idx == 4'd0) begin
                    state_nx  = FIN;
                    dout_nx   = red_out;
                    no_inv_nx = (base == '0);
                end else begin
                    state_nx = SQR;
                    bit_nx   = bit_idx - 4'd1;
                end
            end
            FIN: begin
                state_nx = IDLE;
                acc_nx   = ELEM_W'(1);
                bit_nx   = 4'd9;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mod_inverse_607.sv
// Self-checking bench for mod_inverse_607: directed table, random operands
// against a plain-arithmetic power model, full inverse sweep and control corners.
module tb_mod_inverse_607;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] din_a;
    logic [9:0] dout_r;
    logic       busy;
    logic       done;
    logic       no_inv;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int a;
        int r;
        int ni;
    } vec_t;

    vec_t tbl[9];

    mod_inverse_607 #(.P(607), .EXP(605)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din_a  (din_a),
        .dout_r (dout_r),
        .busy   (busy),
        .done   (done),
        .no_inv (no_inv)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // a^605 mod 607 by repeated multiplication.
    function automatic int ref_pow(input int a);
        int am;
        int r;
        am = a % 607;
        r  = 1;
        for (int i = 0; i < 605; i++) r = (r * am) % 607;
        return r;
    endfunction

    task automatic launch(input int a);
        @(negedge clk);
        din_a = 10'(a);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din_a = 10'($urandom);
    endtask

    // Edges counted inclusive of the edge that sampled start.
    task automatic wait_done(output int edges, output int r, output int ni);
        bit found;
        found = 1'b0;
        edges = 1;
        r     = -1;
        ni    = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                found = 1'b1;
                r     = int'(dout_r);
                ni    = int'(no_inv);
            end
        end
        if (!found) edges = -1;
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        check("dout_hold", int'(dout_r), r);
        check("busy_low_after", int'(busy), 0);
    endtask

    task automatic run_and_check(input string name, input int a, input int exp_r, input int exp_ni);
        int e, r, ni;
        launch(a);
        wait_done(e, r, ni);
        check({name, "_latency"}, e, 17);
        check({name, "_dout"}, r, exp_r);
        check({name, "_no_inv"}, ni, exp_ni);
    endtask

    initial begin
        int a, e, r, ni, ndone, de, e1, e2, r1, r2;

        tbl[0] = '{a: 2,    r: 304, ni: 0};
        tbl[1] = '{a: 3,    r: 405, ni: 0};
        tbl[2] = '{a: 606,  r: 606, ni: 0};
        tbl[3] = '{a: 1,    r: 1,   ni: 0};
        tbl[4] = '{a: 609,  r: 304, ni: 0};
        tbl[5] = '{a: 0,    r: 0,   ni: 1};
        tbl[6] = '{a: 607,  r: 0,   ni: 1};
        tbl[7] = '{a: 5,    r: 243, ni: 0};
        tbl[8] = '{a: 1023, r: ref_pow(1023), ni: 0};

        rst_n = 1'b0;
        start = 1'b0;
        din_a = '0;
        #23;
        check("reset_dout", int'(dout_r), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_no_inv", int'(no_inv), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_and_check("table", tbl[i].a, tbl[i].r, tbl[i].ni);

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 1023));
            run_and_check("random", a, ref_pow(a), ((a % 607) == 0) ? 1 : 0);
        end

        for (int v = 1; v <= 606; v++) begin
            launch(v);
            wait_done(e, r, ni);
            check("sweep_inverse", (v * r) % 607, 1);
        end

        // Extra start pulses before edges 5 and 16 of a running operation.
        launch(5);
        e     = 1;
        ndone = 0;
        de    = -1;
        r     = -1;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            start = (e + 1 == 5 || e + 1 == 16);
            din_a = 10'd3;
            @(posedge clk);
            #1;
            e++;
            if (done) begin
                ndone++;
                de = e;
                r  = int'(dout_r);
            end
            if (e == 10) check("busy_mid_op", int'(busy), 1);
        end
        start = 1'b0;
        check("ignore_done_count", ndone, 1);
        check("ignore_done_edge", de, 17);
        check("ignore_result", r, ref_pow(5));

        // start held high through FIN launches the next operation from IDLE.
        @(negedge clk);
        din_a = 10'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        e  = 1;
        e1 = -1;
        e2 = -1;
        r1 = -1;
        r2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (e1 > 0) din_a = 10'd11;
            if (e >= 19) start = 1'b0;
            @(posedge clk);
            #1;
            e++;
            if (done) begin
                if (e1 < 0) begin
                    e1 = e;
                    r1 = int'(dout_r);
                end else begin
                    e2 = e;
                    r2 = int'(dout_r);
                end
            end
            if (e == 18) check("b2b_idle_gap", int'(busy), 0);
        end
        start = 1'b0;
        check("b2b_first_edge", e1, 17);
        check("b2b_first_result", r1, ref_pow(7));
        check("b2b_second_edge", e2, 35);
        check("b2b_second_result", r2, ref_pow(11));

        // Reset pulse during the squaring phase.
        launch(2);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_dout", int'(dout_r), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_no_inv", int'(no_inv), 0);
        ndone = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midreset_no_done", ndone, 0);
        run_and_check("post_reset", 2, 304, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_inverse_607.md
MOD_INVERSE_607 -- requirements
Module: mod_inverse_607

Interface
REQ-001 Parameter P, default 607, field prime; the only supported value is 607.
REQ-002 Parameter EXP, default 605 (P-2), Fermat inversion exponent.
REQ-003 clk  input  1  single system clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request pulse, sampled only in IDLE.
REQ-006 din_a  input  10  operand, range 0..1023, captured when start is accepted.
REQ-007 dout_r  output  10  result, din_a^-1 mod 607, range 0..606.
REQ-008 busy  output  1  high while an inversion is in progress.
REQ-009 done  output  1  one-cycle pulse marking dout_r valid.
REQ-010 no_inv  output  1  high with done when the reduced operand is 0.

Function
REQ-011 The block SHALL compute dout_r = a^605 mod 607, where a = din_a mod 607, by left-to-right square-and-multiply over EXP bits 9..0 (binary 1001011101).
REQ-012 States SHALL be IDLE, SQR, MUL and FIN: IDLE->SQR on start; SQR->MUL when the current exponent bit = 1; SQR->SQR on the next bit when the bit = 0; MUL->SQR on the next bit; after bit 0 is processed, SQR or MUL SHALL go to FIN; FIN->IDLE unconditionally.
REQ-013 On accept, the block SHALL load acc = 1, base = din_a if din_a < 607 else din_a - 607, and bit index = 9.
REQ-014 SQR SHALL set acc <= (acc*acc) mod 607; MUL SHALL set acc <= (acc*base) mod 607; one modular product per cycle.
REQ-015 Each product SHALL be a 20-bit unsigned multiply of two 10-bit values; bits above 18 are always 0 and SHALL be dropped before reduction.
REQ-016 Latency SHALL be fixed: 10 SQR + 6 MUL = 16 compute cycles, independent of operand value.
REQ-017 done SHALL be high for exactly one cycle, in the FIN state, which begins 17 rising edges after the edge that sampled start.
REQ-018 busy SHALL be high in SQR, MUL and FIN and low in IDLE; start SHALL be ignored while busy is high.
REQ-019 dout_r SHALL update only on entry to FIN and SHALL hold its value until the next FIN; it SHALL NOT expose intermediate acc values.
REQ-020 Operand 0 or 607 SHALL give dout_r = 0 and no_inv = 1 with done; no_inv SHALL hold its value together with dout_r.
REQ-021 start held high across FIN SHALL launch a new operation in the IDLE cycle that immediately follows.

Reset
REQ-022 While rst_n is low, the block SHALL force state = IDLE, dout_r = 0, busy = 0, done = 0, no_inv = 0, acc = 1 and bit index = 9, immediately and without waiting for clk.
REQ-023 Reset during SQR or MUL SHALL abandon the operation with no done pulse; the first start after reset release SHALL behave exactly as after power-up.

Structure
REQ-024 Package gf607_pkg SHALL hold P = 607, EXP = 605, element width 10, product width 19, and the state enumeration.
REQ-025 Exactly one sub-module SHALL be instantiated: the team's combinational Barrett reducer barret_for_607, with din_a (19 bits) and dout_r (10 bits), shared by SQR and MUL through an operand mux.
REQ-026 All state SHALL be registered in one clock domain; there SHALL be no combinational path from start or din_a to any output.

Verification
REQ-027 din_a = 2, start pulse -> done exactly 17 edges later, dout_r = 304, no_inv = 0.
REQ-028 din_a = 3 -> 405; din_a = 606 -> 606; din_a = 1 -> 1.
REQ-029 din_a = 609 (unreduced) -> 304; din_a = 0 -> dout_r = 0 with no_inv = 1; din_a = 607 -> no_inv = 1.
REQ-030 Exhaustive sweep of din_a over 1..606 -> (din_a*dout_r) mod 607 = 1 for every value, with results logged to result_inv_607.out.
REQ-031 start pulsed again at cycles 5 and 16 of an active operation -> both ignored, a single done; back-to-back start held high through FIN -> second result 17 edges after the IDLE cycle.
REQ-032 rst_n pulsed low mid-SQR -> outputs zero immediately, no done pulse; the next start returns a correct result.
